// File: rtl/piezo_tone_sequencer.sv
// Sequencer for the piezo tone generator: plays an 8-note C4..C5 melody and
// services higher-priority key beeps that pre-empt and then resume the melody.
module piezo_tone_sequencer #(
    parameter int TICK_DIV   = 10000,
    parameter int NOTE_TICKS = 25,
    parameter int GAP_TICKS  = 5,
    parameter int BEEP_TICKS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        melody_start,
    input  logic        melody_stop,
    input  logic        beep_req,
    input  logic [2:0]  beep_note,
    output logic [10:0] half_period,
    output logic        tone_en,
    output logic        busy,
    output logic        melody_done
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MEL_NOTE = 2'd1;
    localparam logic [1:0] MEL_GAP  = 2'd2;
    localparam logic [1:0] BEEP     = 2'd3;

    localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_NG    = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int MAX_TICKS = (MAX_NG > BEEP_TICKS) ? MAX_NG : BEEP_TICKS;
    localparam int DUR_W     = $clog2(MAX_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]  NOTE_LAST = DUR_W'(NOTE_TICKS - 1);
    localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_TICKS - 1);
    localparam logic [DUR_W-1:0]  BEEP_LAST = DUR_W'(BEEP_TICKS - 1);

    function automatic logic [10:0] note_hp(input logic [2:0] code);
        case (code)
            3'd0:    note_hp = 11'd1911;
            3'd1:    note_hp = 11'd1702;
            3'd2:    note_hp = 11'd1516;
            3'd3:    note_hp = 11'd1431;
            3'd4:    note_hp = 11'd1275;
            3'd5:    note_hp = 11'd1135;
            3'd6:    note_hp = 11'd1011;
            default: note_hp = 11'd955;
        endcase
    endfunction

    logic [1:0]        state, nstate;
    logic [2:0]        step, nstep;
    logic [2:0]        beep_code, nbeep;
    logic              pending, npend;
    // set when a beep pre-empted the final gap: resuming just completes the melody
    logic              fin, nfin;
    logic [TICK_W-1:0] tick_cnt;
    logic [DUR_W-1:0]  dur_cnt, dur_last;
    logic              tick, last, enter, ndone;

    always_comb begin
        case (state)
            MEL_NOTE: dur_last = NOTE_LAST;
            MEL_GAP:  dur_last = GAP_LAST;
            default:  dur_last = BEEP_LAST;
        endcase
    end

    assign tick = (tick_cnt == TICK_LAST);
    assign last = tick && (dur_cnt == dur_last);

    always_comb begin
        nstate = state;
        nstep  = step;
        npend  = pending;
        nfin   = fin;
        nbeep  = beep_code;
        enter  = 1'b0;
        ndone  = 1'b0;
        case (state)
            IDLE: begin
                if (beep_req) begin
                    nstate = BEEP;
                    nbeep  = beep_note;
                    enter  = 1'b1;
                    if (melody_start && !melody_stop) begin
                        npend = 1'b1;
                        nstep = 3'd0;
                    end
                end else if (melody_start && !melody_stop) begin
                    nstate = MEL_NOTE;
                    nstep  = 3'd0;
                    enter  = 1'b1;
                end
            end
            MEL_NOTE, MEL_GAP: begin
                if (melody_stop) begin
                    npend  = 1'b0;
                    nstep  = 3'd0;
                    nfin   = 1'b0;
                    enter  = 1'b1;
                    nstate = beep_req ? BEEP : IDLE;
                    if (beep_req) nbeep = beep_note;
                end else if (beep_req) begin
                    nstate = BEEP;
                    nbeep  = beep_note;
                    enter  = 1'b1;
                    npend  = 1'b1;
                    if (state == MEL_GAP) begin
                        if (step == 3'd7) nfin  = 1'b1;
                        else              nstep = step + 3'd1;
                    end
                end else if (last) begin
                    enter = 1'b1;
                    if (state == MEL_NOTE) begin
                        nstate = MEL_GAP;
                    end else if (step == 3'd7) begin
                        nstate = IDLE;
                        nstep  = 3'd0;
                        ndone  = 1'b1;
                    end else begin
                        nstate = MEL_NOTE;
                        nstep  = step + 3'd1;
                    end
                end
            end
            BEEP: begin
                if (melody_stop) begin
                    npend = 1'b0;
                    nstep = 3'd0;
                    nfin  = 1'b0;
                end else if (melody_start && !pending) begin
                    npend = 1'b1;
                    nstep = 3'd0;
                    nfin  = 1'b0;
                end
                if (beep_req) begin
                    nbeep = beep_note;
                    enter = 1'b1;
                end else if (last) begin
                    enter = 1'b1;
                    if (npend && nfin) begin
                        nstate = IDLE;
                        npend  = 1'b0;
                        nfin   = 1'b0;
                        nstep  = 3'd0;
                        ndone  = 1'b1;
                    end else if (npend) begin
                        nstate = MEL_NOTE;
                        npend  = 1'b0;
                    end else begin
                        nstate = IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            step        <= 3'd0;
            beep_code   <= 3'd0;
            pending     <= 1'b0;
            fin         <= 1'b0;
            tick_cnt    <= '0;
            dur_cnt     <= '0;
            half_period <= 11'd0;
            tone_en     <= 1'b0;
            busy        <= 1'b0;
            melody_done <= 1'b0;
        end else begin
            state     <= nstate;
            step      <= nstep;
            beep_code <= nbeep;
            pending   <= npend;
            fin       <= nfin;
            if (enter || nstate == IDLE) begin
                tick_cnt <= '0;
                dur_cnt  <= '0;
            end else if (tick) begin
                tick_cnt <= '0;
                dur_cnt  <= dur_cnt + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (nstate == MEL_NOTE)  half_period <= note_hp(nstep);
            else if (nstate == BEEP) half_period <= note_hp(nbeep);
            tone_en     <= (nstate == MEL_NOTE) || (nstate == BEEP);
            busy        <= (nstate != IDLE) || npend;
            melody_done <= ndone;
        end
    end

endmodule

// File: tb/tb_piezo_tone_sequencer.sv
// Bench for piezo_tone_sequencer: directed scenarios plus random pulses,
// checked every cycle against a countdown-based behavioural model.
module tb_piezo_tone_sequencer;

    localparam int TD = 4, NT = 3, GT = 2, BT = 2;
    localparam int NOTE_CLK = NT * TD;
    localparam int GAP_CLK  = GT * TD;
    localparam int BEEP_CLK = BT * TD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        melody_start = 1'b0, melody_stop = 1'b0, beep_req = 1'b0;
    logic [2:0]  beep_note = 3'd0;
    logic [10:0] half_period;
    logic        tone_en, busy, melody_done;

    piezo_tone_sequencer #(.TICK_DIV(TD), .NOTE_TICKS(NT), .GAP_TICKS(GT), .BEEP_TICKS(BT)) dut (
        .clk(clk), .reset(reset), .melody_start(melody_start), .melody_stop(melody_stop),
        .beep_req(beep_req), .beep_note(beep_note), .half_period(half_period),
        .tone_en(tone_en), .busy(busy), .melody_done(melody_done)
    );

    always #5 clk = ~clk;

    int tbl [8] = '{1911, 1702, 1516, 1431, 1275, 1135, 1011, 955};

    // Model: which activity is sounding, clocks left in it, melody position
    // (8 = melody already finished, only the completion is outstanding).
    bit m_note, m_gap, m_beep, m_pend, m_done;
    int m_rem, m_pos, m_hp;

    int npass = 0, nchk = 0;
    int edge_no = 0, mel_ref = 0, done_cnt = 0, done_edge = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_note = 0; m_gap = 0; m_beep = 0; m_pend = 0; m_done = 0;
        m_rem = 0; m_pos = 0; m_hp = 0;
    endtask

    task automatic go_idle();
        m_note = 0; m_gap = 0; m_beep = 0; m_rem = 0;
    endtask

    task automatic go_note(input int p);
        m_note = 1; m_gap = 0; m_beep = 0; m_rem = NOTE_CLK; m_hp = tbl[p];
    endtask

    task automatic go_gap();
        m_note = 0; m_gap = 1; m_beep = 0; m_rem = GAP_CLK;
    endtask

    task automatic go_beep(input int n);
        m_note = 0; m_gap = 0; m_beep = 1; m_rem = BEEP_CLK; m_hp = tbl[n];
    endtask

    task automatic model_edge(input bit st, input bit sp, input bit br, input int bn);
        m_done = 0;
        if (m_beep) begin
            if (sp) begin m_pend = 0; m_pos = 0; end
            else if (st && !m_pend) begin m_pend = 1; m_pos = 0; end
            if (br) go_beep(bn);
            else begin
                m_rem--;
                if (m_rem == 0) begin
                    if (!m_pend) go_idle();
                    else if (m_pos == 8) begin m_pend = 0; m_pos = 0; m_done = 1; go_idle(); end
                    else begin m_pend = 0; go_note(m_pos); end
                end
            end
        end else if (m_note || m_gap) begin
            if (sp) begin
                m_pend = 0; m_pos = 0;
                if (br) go_beep(bn); else go_idle();
            end else if (br) begin
                m_pend = 1;
                if (m_gap) m_pos++;
                go_beep(bn);
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_note) go_gap();
                    else begin
                        m_pos++;
                        if (m_pos == 8) begin m_pos = 0; m_done = 1; go_idle(); end
                        else go_note(m_pos);
                    end
                end
            end
        end else begin
            if (br) begin
                go_beep(bn);
                if (st && !sp) begin m_pend = 1; m_pos = 0; end
            end else if (st && !sp) begin
                m_pos = 0; go_note(0);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(melody_start, melody_stop, beep_req, int'(beep_note));
        edge_no++;
        #1;
        if (melody_done === 1'b1) begin
            done_cnt++;
            done_edge = edge_no - mel_ref;
        end
        chk("tone_en", 32'(tone_en), 32'(m_note || m_beep));
        chk("half_period", 32'(half_period), 32'(m_hp));
        chk("busy", 32'(busy), 32'(m_note || m_gap || m_beep || m_pend));
        chk("melody_done", 32'(melody_done), 32'(m_done));
        melody_start = 1'b0;
        melody_stop  = 1'b0;
        beep_req     = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        model_reset();
        run(3);
        chk("reset_tone_en", 32'(tone_en), 32'd0);
        chk("reset_half_period", 32'(half_period), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        run(3);

        // full melody from IDLE
        melody_start = 1'b1;
        cyc();
        mel_ref = edge_no; done_cnt = 0; done_edge = -1;
        chk("mel_first_note", 32'(half_period), 32'd1911);
        run(170);
        chk("mel_done_count", 32'(done_cnt), 32'd1);
        chk("mel_done_edge", 32'(done_edge), 32'd160);
        chk("mel_idle_busy", 32'(busy), 32'd0);

        // plain beep from IDLE
        beep_note = 3'd5; beep_req = 1'b1;
        cyc();
        done_cnt = 0;
        chk("beep_hp", 32'(half_period), 32'd1135);
        run(7);
        chk("beep_still_on", 32'(tone_en), 32'd1);
        cyc();
        chk("beep_off", 32'(tone_en), 32'd0);
        chk("beep_busy", 32'(busy), 32'd0);
        run(4);
        chk("beep_no_done", 32'(done_cnt), 32'd0);

        // beep pre-empting melody step 2 note
        melody_start = 1'b1;
        cyc();
        mel_ref = edge_no; done_cnt = 0;
        run(43);
        beep_note = 3'd7; beep_req = 1'b1;
        cyc();
        chk("preempt_beep_hp", 32'(half_period), 32'd955);
        run(8);
        chk("resume_hp", 32'(half_period), 32'd1516);
        chk("resume_en", 32'(tone_en), 32'd1);
        run(140);
        chk("preempt_done_count", 32'(done_cnt), 32'd1);

        // start and beep together
        melody_start = 1'b1; beep_req = 1'b1; beep_note = 3'd0;
        cyc();
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("joint_busy", 32'(busy), 32'd1);
        end
        chk("joint_melody_hp", 32'(half_period), 32'd1911);
        run(160);
        chk("joint_done_count", 32'(done_cnt), 32'd1);

        // stop during step 4, then restart
        melody_start = 1'b1;
        cyc();
        done_cnt = 0;
        run(82);
        chk("stop_pre_hp", 32'(half_period), 32'd1275);
        melody_stop = 1'b1;
        cyc();
        chk("stop_tone_en", 32'(tone_en), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        run(30);
        chk("stop_no_done", 32'(done_cnt), 32'd0);
        melody_start = 1'b1;
        cyc();
        chk("restart_hp", 32'(half_period), 32'd1911);

        // asynchronous reset mid-note
        run(5);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_tone_en", 32'(tone_en), 32'd0);
        chk("areset_half_period", 32'(half_period), 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        model_reset();
        run(2);
        reset = 1'b0;
        run(2);

        // random pulses
        for (int i = 0; i < 3000; i++) begin
            melody_start = ($urandom_range(0, 39) == 0);
            melody_stop  = ($urandom_range(0, 149) == 0);
            beep_req     = ($urandom_range(0, 59) == 0);
            beep_note    = 3'($urandom_range(0, 7));
            cyc();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
